// File: rtl/in_mux_cfg_pkg.sv
// Shared constants and types for the 9-channel input mux configuration controller.
package in_mux_cfg_pkg;
  localparam int N_CH  = 9;
  localparam int SEL_W = 8;

  localparam logic [3:0] ADDR_EDGE_LO = 4'd9;
  localparam logic [3:0] ADDR_EDGE_HI = 4'd10;
  localparam logic [3:0] ADDR_COMMIT  = 4'd11;
  localparam logic [3:0] ADDR_CLR     = 4'd12;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_BLANK} cfgState_t;

  typedef logic [N_CH-1:0][SEL_W-1:0] selBank_t;

  // Identity routing: channel i selects input i.
  localparam selBank_t SEL_RESET = 72'h08_0706_0504_0302_0100;

  typedef struct packed {
    logic       en;
    logic [3:0] addr;
    logic [7:0] data;
  } wrReq_t;
endpackage

// File: rtl/in_mux_cfg_regs.sv
// Shadow and active select/edge banks; shadow is written by the host, active loads on strobe.
module in_mux_cfg_regs
  import in_mux_cfg_pkg::*;
(
  input  logic            clk320,
  input  logic            rst,
  input  wrReq_t          wr,
  input  logic            load,
  output selBank_t        actSel,
  output logic [N_CH-1:0] actEdge
);
  selBank_t        shSel;
  logic [N_CH-1:0] shEdge;

  always_ff @(posedge clk320 or negedge rst) begin
    if (!rst) begin
      shSel   <= SEL_RESET;
      shEdge  <= '0;
      actSel  <= SEL_RESET;
      actEdge <= '0;
    end else begin
      if (wr.en) begin
        for (int i = 0; i < N_CH; i++)
          if (wr.addr == 4'(i)) shSel[i] <= wr.data;
        if (wr.addr == ADDR_EDGE_LO) shEdge[SEL_W-1:0] <= wr.data;
        if (wr.addr == ADDR_EDGE_HI) shEdge[N_CH-1]    <= wr.data[0];
      end
      // Whole bank moves in one edge so downstream never sees a mixed set.
      if (load) begin
        actSel  <= shSel;
        actEdge <= shEdge;
      end
    end
  end
endmodule

// File: rtl/in_mux_cfg_ctrl.sv
// Commit sequencer: waits for frame sync (or timeout), swaps shadow to active, then blanks.
module in_mux_cfg_ctrl
  import in_mux_cfg_pkg::*;
#(
  parameter int BLANK_CYC = 4,
  parameter int SYNC_TO   = 1024
) (
  input  logic                  clk320,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  sync,
  output logic [N_CH*SEL_W-1:0] cfg_setting,
  output logic [N_CH-1:0]       cfg_edge_sel,
  output logic                  blank,
  output logic                  cfg_done,
  output logic                  err_range,
  output logic                  err_addr,
  output logic                  err_sync
);
  localparam int CNT_MAX = (SYNC_TO > BLANK_CYC) ? SYNC_TO : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  cfgState_t  state;
  logic [CNT_W-1:0] cnt;
  wrReq_t     wrReq;
  selBank_t   actSel;
  logic       timeout, leavePend;
  logic       commitHit, clrHit, rangeErr, addrErr;

  assign wr_ready  = (state == ST_IDLE);
  assign wrReq     = '{en: wr_valid & wr_ready, addr: wr_addr, data: wr_data};
  assign timeout   = (cnt == CNT_W'(SYNC_TO-1));
  assign leavePend = (state == ST_PEND) && (sync || timeout);

  assign commitHit = wrReq.en && (wr_addr == ADDR_COMMIT);
  assign clrHit    = wrReq.en && (wr_addr == ADDR_CLR);
  assign rangeErr  = wrReq.en && (wr_addr <= 4'(N_CH-1)) && (wr_data > 8'(N_CH-1));
  assign addrErr   = wrReq.en && (wr_addr > ADDR_CLR);

  in_mux_cfg_regs uRegs (
    .clk320  (clk320),
    .rst     (rst),
    .wr      (wrReq),
    .load    (leavePend),
    .actSel  (actSel),
    .actEdge (cfg_edge_sel)
  );
  assign cfg_setting = actSel;

  always_ff @(posedge clk320 or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      blank     <= 1'b0;
      cfg_done  <= 1'b0;
      err_range <= 1'b0;
      err_addr  <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE: if (commitHit) begin
          state <= ST_PEND;
          cnt   <= '0;
        end
        ST_PEND: if (leavePend) begin
          state <= ST_BLANK;
          blank <= 1'b1;
          cnt   <= '0;
          if (!sync) err_sync <= 1'b1;  // sync on the timeout cycle still counts as on time
        end else begin
          cnt <= cnt + 1'b1;
        end
        ST_BLANK: if (cnt == CNT_W'(BLANK_CYC-1)) begin
          state    <= ST_IDLE;
          blank    <= 1'b0;
          cfg_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (clrHit) begin
        err_range <= 1'b0;
        err_addr  <= 1'b0;
        err_sync  <= 1'b0;
      end
      if (rangeErr) err_range <= 1'b1;
      if (addrErr)  err_addr  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_in_mux_cfg_ctrl.sv
// Directed bench: stimulus pushes expected commit results, a monitor checks them on cfg_done.
module tb_in_mux_cfg_ctrl;
  localparam int BLANK_CYC = 4;
  localparam int SYNC_TO   = 16;
  localparam logic [71:0] ID_VEC = 72'h08_0706_0504_0302_0100;
  localparam logic [71:0] VEC_A  = 72'h08_0706_0504_0702_0100;
  localparam logic [71:0] VEC_B  = 72'h08_0706_0504_0702_010C;
  localparam logic [71:0] VEC_C  = 72'h08_0706_0504_0755_010C;

  logic        clk320 = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        sync = 1'b0;
  logic [71:0] cfg_setting;
  logic [8:0]  cfg_edge_sel;
  logic        blank, cfg_done, err_range, err_addr, err_sync;

  typedef struct {
    logic [71:0] setting;
    logic [8:0]  edgeSel;
    logic        errSync;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  int   blankRun = 0;

  in_mux_cfg_ctrl #(.BLANK_CYC(BLANK_CYC), .SYNC_TO(SYNC_TO)) dut (
    .clk320       (clk320),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .sync         (sync),
    .cfg_setting  (cfg_setting),
    .cfg_edge_sel (cfg_edge_sel),
    .blank        (blank),
    .cfg_done     (cfg_done),
    .err_range    (err_range),
    .err_addr     (err_addr),
    .err_sync     (err_sync)
  );

  always #5 clk320 = ~clk320;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk320);
    #1;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("wr_ready_timeout", 72'(wr_ready), 72'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    int n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    waitReady(n);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulseSync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  // Scoreboard side: every cfg_done must match the oldest pushed commit result.
  always @(negedge clk320) begin
    if (!rst) begin
      blankRun = 0;
    end else begin
      if (blank) blankRun++;
      if (cfg_done) begin
        if (expQ.size() == 0) begin
          chk("done_unexpected", 72'd1, 72'd0);
        end else begin
          monExp = expQ.pop_front();
          chk("done_setting", cfg_setting, monExp.setting);
          chk("done_edge", 72'(cfg_edge_sel), 72'(monExp.edgeSel));
          chk("done_err_sync", 72'(err_sync), 72'(monExp.errSync));
          chk("done_blank_len", 72'(blankRun), 72'(BLANK_CYC));
          chk("done_wr_ready", 72'(wr_ready), 72'd1);
        end
        blankRun = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_setting", cfg_setting, ID_VEC);
    chk("rst_edge", 72'(cfg_edge_sel), 72'd0);
    chk("rst_wr_ready", 72'(wr_ready), 72'd1);
    chk("rst_blank", 72'(blank), 72'd0);
    chk("rst_done", 72'(cfg_done), 72'd0);
    chk("rst_errs", 72'({err_range, err_addr, err_sync}), 72'd0);

    // Basic commit with sync five cycles after the COMMIT write.
    wr(4'd3, 8'h07);
    wr(4'd9, 8'hA5);
    chk("shadow_hidden", cfg_setting, ID_VEC);
    expQ.push_back('{VEC_A, 9'h0A5, 1'b0});
    wr(4'd11, 8'h00);
    chk("pend_wr_ready", 72'(wr_ready), 72'd0);
    repeat (4) tick();
    chk("pre_sync_setting", cfg_setting, ID_VEC);
    chk("pre_sync_edge", 72'(cfg_edge_sel), 72'd0);
    pulseSync();
    chk("post_sync_setting", cfg_setting, VEC_A);
    chk("post_sync_edge", 72'(cfg_edge_sel), 72'h0A5);
    chk("post_sync_blank", 72'(blank), 72'd1);
    waitReady(n);
    chk("blank_to_ready", 72'(n), 72'(BLANK_CYC));

    // Sync while idle is ignored.
    pulseSync();
    tick();
    chk("idle_sync_blank", 72'(blank), 72'd0);
    chk("idle_sync_ready", 72'(wr_ready), 72'd1);

    // Timeout; the sync coincident with COMMIT must not count.
    expQ.push_back('{VEC_A, 9'h0A5, 1'b1});
    wr_valid = 1'b1;
    wr_addr  = 4'd11;
    sync     = 1'b1;
    tick();
    wr_valid = 1'b0;
    sync     = 1'b0;
    n = 0;
    while (!blank && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 72'(n), 72'(SYNC_TO));
    chk("timeout_err_sync", 72'(err_sync), 72'd1);
    waitReady(n);
    wr(4'd12, 8'h00);
    chk("clr_err_sync", 72'(err_sync), 72'd0);

    // Range and address errors; out-of-range value is still stored.
    wr(4'd0, 8'd12);
    chk("err_range_set", 72'(err_range), 72'd1);
    wr(4'd14, 8'hFF);
    chk("err_addr_set", 72'(err_addr), 72'd1);
    wr(4'd10, 8'h01);
    chk("errs_sticky", 72'({err_range, err_addr}), 72'h3);
    wr(4'd12, 8'h00);
    chk("clr_errs", 72'({err_range, err_addr, err_sync}), 72'd0);

    // Sync on exactly the timeout cycle: sync wins, no err_sync.
    expQ.push_back('{VEC_B, 9'h1A5, 1'b0});
    wr(4'd11, 8'h00);
    repeat (SYNC_TO - 1) tick();
    chk("tie_no_blank_yet", 72'(blank), 72'd0);
    pulseSync();
    chk("tie_blank", 72'(blank), 72'd1);
    chk("tie_err_sync", 72'(err_sync), 72'd0);
    waitReady(n);

    // Write held during PEND/BLANK is only taken in the first idle cycle.
    expQ.push_back('{VEC_B, 9'h1A5, 1'b0});
    wr(4'd11, 8'h00);
    wr_valid = 1'b1;
    wr_addr  = 4'd2;
    wr_data  = 8'h55;
    tick();
    pulseSync();
    wr(4'd2, 8'h55);
    expQ.push_back('{VEC_C, 9'h1A5, 1'b0});
    wr(4'd11, 8'h00);
    tick();
    pulseSync();
    waitReady(n);

    // Reset during BLANK drops everything, the pending commit included.
    wr(4'd11, 8'h00);
    tick();
    pulseSync();
    chk("pre_rst_blank", 72'(blank), 72'd1);
    rst = 1'b0;
    #2;
    chk("mid_rst_blank", 72'(blank), 72'd0);
    chk("mid_rst_setting", cfg_setting, ID_VEC);
    chk("mid_rst_edge", 72'(cfg_edge_sel), 72'd0);
    chk("mid_rst_ready", 72'(wr_ready), 72'd1);
    tick();
    rst = 1'b1;
    pulseSync();
    tick();
    chk("post_rst_sync_setting", cfg_setting, ID_VEC);
    chk("post_rst_sync_blank", 72'(blank), 72'd0);
    expQ.push_back('{ID_VEC, 9'h000, 1'b0});
    wr(4'd11, 8'h00);
    pulseSync();
    waitReady(n);

    repeat (3) tick();
    chk("queue_empty", 72'(expQ.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
